parking_exit_gate: RTL and testbench



---
 rtl/parking_pkg.sv | 21 ++
 rtl/parking_occupancy_cnt.sv | 37 +++
 rtl/parking_exit_gate.sv | 130 +++++++++++++
 tb/tb_parking_exit_gate.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared definitions for the car-park gate controllers: FSM state encodings and
// active-low 7-segment glyphs in bit order {g,f,e,d,c,b,a}.
package parking_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_TOKEN = 3'd1,
      DENY       = 3'd2,
      OPEN       = 3'd3,
      STOP       = 3'd4
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_E     = 7'b000_0110;
   localparam logic [6:0] SEG_H     = 7'b000_1001;
   localparam logic [6:0] SEG_6     = 7'b000_0010;
   localparam logic [6:0] SEG_0     = 7'b100_0000;
   localparam logic [6:0] SEG_5     = 7'b001_0010;
   localparam logic [6:0] SEG_P     = 7'b000_1100;

endpackage

// File: rtl/parking_occupancy_cnt.sv
// Saturating up/down occupancy counter; simultaneous inc and dec cancel out.
// lot_full is registered together with the count.
module parking_occupancy_cnt #(
   parameter int CAPACITY = 15,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] occupancy,
   output logic             lot_full
);

   localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

   logic [CNT_W-1:0] occ_nxt;

   always_comb begin
      occ_nxt = occupancy;
      if (inc && !dec && occupancy != CAP)
         occ_nxt = occupancy + 1'b1;
      else if (dec && !inc && occupancy != '0)
         occ_nxt = occupancy - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occupancy <= '0;
         lot_full  <= 1'b0;
      end else begin
         occupancy <= occ_nxt;
         lot_full  <= (occ_nxt == CAP);
      end
   end

endmodule

// File: rtl/parking_exit_gate.sv
// Exit-side gate controller: token check, tailgate stop, lamps, 7-seg and occupancy.
// Optional EXIT_TIMEOUT_EN: DENY falls back to IDLE after TIMEOUT_CYC cycles.
module parking_exit_gate
   import parking_pkg::*;
#(
   parameter logic [1:0] EXIT_CODE   = 2'b11,
   parameter int         WAIT_CYC    = 3,
   parameter int         CAPACITY    = 15,
   parameter int         CNT_W       = 4,
   parameter int         TIMEOUT_CYC = 16
) (
   input  logic             clock_in,
   input  logic             rst_in,
   input  logic             Inner_Sensor,
   input  logic             Outer_Sensor,
   input  logic [1:0]       token,
   input  logic             entry_event,
   output logic             G_LED,
   output logic             R_LED,
   output logic [6:0]       HEX_1,
   output logic [6:0]       HEX_2,
   output logic [CNT_W-1:0] occupancy,
   output logic             lot_full,
   output logic             exit_event
);

   localparam int WAIT_W = $clog2(WAIT_CYC + 2);
   localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_CYC);

   if (CAPACITY >= 2**CNT_W || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("parking_exit_gate: CAPACITY must fit in CNT_W and TIMEOUT_CYC must be >= 1");
   end

   state_t            ps, ns;
   logic [WAIT_W-1:0] cnt_wait;
   logic              tok_ok, timeout;
   logic              g_nxt, r_nxt;
   logic [6:0]        hex1_nxt, hex2_nxt;

   assign tok_ok = (token == EXIT_CODE);

`ifdef EXIT_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
   logic [TMR_W-1:0] deny_tmr;

   // Timer idles at zero outside DENY, so every DENY visit starts fresh.
   always_ff @(posedge clock_in or negedge rst_in) begin
      if (!rst_in)         deny_tmr <= '0;
      else if (ps == DENY) deny_tmr <= deny_tmr + 1'b1;
      else                 deny_tmr <= '0;
   end
   assign timeout = (ps == DENY) && (deny_tmr == TMR_LAST);
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clock_in or negedge rst_in) begin
      if (!rst_in) begin
         ps       <= IDLE;
         cnt_wait <= '0;
      end else begin
         ps       <= ns;
         cnt_wait <= (ps == WAIT_TOKEN && ns == WAIT_TOKEN) ? cnt_wait + 1'b1 : '0;
      end
   end

   always_comb begin
      ns = ps;
      case (ps)
         IDLE:       if (Inner_Sensor) ns = WAIT_TOKEN;
         WAIT_TOKEN: if (cnt_wait > WAIT_LIM) ns = tok_ok ? OPEN : DENY;
         DENY: begin
            // A valid token beats both back-away and timeout.
            if (tok_ok)             ns = OPEN;
            else if (!Inner_Sensor) ns = IDLE;
            else if (timeout)       ns = IDLE;
         end
         OPEN: begin
            if (Inner_Sensor && Outer_Sensor) ns = STOP;
            else if (Outer_Sensor)            ns = IDLE;
         end
         STOP:       if (tok_ok) ns = OPEN;
         default:    ns = IDLE;
      endcase
   end

   always_comb begin
      g_nxt    = 1'b0;
      r_nxt    = 1'b0;
      hex1_nxt = SEG_BLANK;
      hex2_nxt = SEG_BLANK;
      case (ps)
         WAIT_TOKEN: begin r_nxt = 1'b1;   hex1_nxt = SEG_E; hex2_nxt = SEG_H; end
         DENY:       begin r_nxt = ~R_LED; hex1_nxt = SEG_E; hex2_nxt = SEG_E; end
         OPEN:       begin g_nxt = ~G_LED; hex1_nxt = SEG_6; hex2_nxt = SEG_0; end
         STOP:       begin r_nxt = ~R_LED; hex1_nxt = SEG_5; hex2_nxt = SEG_P; end
         default:    ;
      endcase
   end

   always_ff @(posedge clock_in or negedge rst_in) begin
      if (!rst_in) begin
         G_LED      <= 1'b0;
         R_LED      <= 1'b0;
         HEX_1      <= SEG_BLANK;
         HEX_2      <= SEG_BLANK;
         exit_event <= 1'b0;
      end else begin
         G_LED      <= g_nxt;
         R_LED      <= r_nxt;
         HEX_1      <= hex1_nxt;
         HEX_2      <= hex2_nxt;
         exit_event <= (ps == OPEN) && (ns == IDLE);
      end
   end

   parking_occupancy_cnt #(
      .CAPACITY (CAPACITY),
      .CNT_W    (CNT_W)
   ) u_occ (
      .clk       (clock_in),
      .rst_n     (rst_in),
      .inc       (entry_event),
      .dec       (exit_event),
      .occupancy (occupancy),
      .lot_full  (lot_full)
   );

endmodule

// File: tb/tb_parking_exit_gate.sv
// Directed bench for parking_exit_gate; DENY-timeout expectation follows EXIT_TIMEOUT_EN.
module tb_parking_exit_gate;

   localparam logic [6:0] BLK = 7'h7F;
   localparam logic [6:0] S_E = 7'b000_0110;
   localparam logic [6:0] S_H = 7'b000_1001;
   localparam logic [6:0] S_6 = 7'b000_0010;
   localparam logic [6:0] S_0 = 7'b100_0000;
   localparam logic [6:0] S_5 = 7'b001_0010;
   localparam logic [6:0] S_P = 7'b000_1100;

   logic       clock_in = 1'b0;
   logic       rst_in;
   logic       Inner_Sensor, Outer_Sensor, entry_event;
   logic [1:0] token;
   logic       G_LED, R_LED, lot_full, exit_event;
   logic [6:0] HEX_1, HEX_2;
   logic [3:0] occupancy;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clock_in = ~clock_in;

   parking_exit_gate dut (
      .clock_in     (clock_in),
      .rst_in       (rst_in),
      .Inner_Sensor (Inner_Sensor),
      .Outer_Sensor (Outer_Sensor),
      .token        (token),
      .entry_event  (entry_event),
      .G_LED        (G_LED),
      .R_LED        (R_LED),
      .HEX_1        (HEX_1),
      .HEX_2        (HEX_2),
      .occupancy    (occupancy),
      .lot_full     (lot_full),
      .exit_event   (exit_event)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clock_in);
   endtask

   initial begin
      rst_in = 1'b0; Inner_Sensor = 1'b0; Outer_Sensor = 1'b0;
      token = 2'b00; entry_event = 1'b0;
      step(1);
      chk("rst_g", G_LED, 0);       chk("rst_r", R_LED, 0);
      chk("rst_h1", HEX_1, BLK);    chk("rst_h2", HEX_2, BLK);
      chk("rst_occ", occupancy, 0); chk("rst_full", lot_full, 0);
      chk("rst_exit", exit_event, 0);

      // 1: valid token held, five-cycle WAIT dwell, then exit
      rst_in = 1'b1; Inner_Sensor = 1'b1; token = 2'b11;
      step(2);
      chk("t1_wait_r", R_LED, 1); chk("t1_wait_h1", HEX_1, S_E); chk("t1_wait_h2", HEX_2, S_H);
      step(4);
      chk("t1_dwell_h1", HEX_1, S_E);
      step(1);
      chk("t1_open_h1", HEX_1, S_6); chk("t1_open_h2", HEX_2, S_0);
      chk("t1_open_g", G_LED, 1);    chk("t1_open_r", R_LED, 0);
      step(1);
      chk("t1_g_toggle", G_LED, 0);
      Inner_Sensor = 1'b0; Outer_Sensor = 1'b1;
      step(1);
      chk("t1_exit_pulse", exit_event, 1);
      step(1);
      chk("t1_exit_clear", exit_event, 0); chk("t1_idle_h1", HEX_1, BLK);
      chk("t5_occ_floor", occupancy, 0);

      // 2: wrong token -> DENY, then valid token
      Outer_Sensor = 1'b0; entry_event = 1'b1; token = 2'b01;
      step(3);
      chk("t2_occ3", occupancy, 3);
      entry_event = 1'b0; Inner_Sensor = 1'b1;
      step(7);
      chk("t2_deny_h1", HEX_1, S_E); chk("t2_deny_h2", HEX_2, S_E); chk("t2_deny_r0", R_LED, 0);
      step(1);
      chk("t2_deny_r1", R_LED, 1);
      token = 2'b11;
      step(2);
      chk("t2_open_h1", HEX_1, S_6); chk("t2_open_g", G_LED, 1);
      Inner_Sensor = 1'b0; Outer_Sensor = 1'b1;
      step(1);
      chk("t2_exit_pulse", exit_event, 1);
      step(1);
      chk("t2_occ2", occupancy, 2);

      // 3: tailgate -> STOP, valid token reopens
      Outer_Sensor = 1'b0; Inner_Sensor = 1'b1; token = 2'b11;
      step(7);
      chk("t3_open_h1", HEX_1, S_6);
      Outer_Sensor = 1'b1; token = 2'b00;
      step(2);
      chk("t3_stop_h1", HEX_1, S_5); chk("t3_stop_h2", HEX_2, S_P);
      chk("t3_stop_g", G_LED, 0);    chk("t3_stop_r1", R_LED, 1);
      step(1);
      chk("t3_stop_r0", R_LED, 0);   chk("t3_stop_hold", HEX_1, S_5);
      token = 2'b11; Inner_Sensor = 1'b0; Outer_Sensor = 1'b0;
      step(2);
      chk("t3_reopen_h1", HEX_1, S_6);
      Outer_Sensor = 1'b1; token = 2'b00;
      step(1);
      chk("t3_exit_pulse", exit_event, 1);
      step(1);
      chk("t3_occ1", occupancy, 1);

      // 4: saturation at capacity, coincident entry/exit
      Outer_Sensor = 1'b0; entry_event = 1'b1;
      step(16);
      chk("t4_occ15", occupancy, 15); chk("t4_full", lot_full, 1);
      step(1);
      chk("t4_sat", occupancy, 15);
      entry_event = 1'b0; Inner_Sensor = 1'b1; token = 2'b11;
      step(7);
      Inner_Sensor = 1'b0; Outer_Sensor = 1'b1;
      step(1);
      chk("t4_exit_pulse", exit_event, 1);
      entry_event = 1'b1;
      step(1);
      chk("t4_coincident", occupancy, 15); chk("t4_full_hold", lot_full, 1);
      entry_event = 1'b0; Outer_Sensor = 1'b0; Inner_Sensor = 1'b1;
      step(7);
      Inner_Sensor = 1'b0; Outer_Sensor = 1'b1;
      step(2);
      chk("t4_occ14", occupancy, 14); chk("t4_not_full", lot_full, 0);

      // 6: long DENY with wrong token, then back-away, then reset while OPEN
      Outer_Sensor = 1'b0; Inner_Sensor = 1'b1; token = 2'b01;
      step(7);
      chk("t6_deny_h2", HEX_2, S_E);
      step(16);
`ifdef EXIT_TIMEOUT_EN
      chk("t6_timeout", HEX_2, BLK);
`else
      chk("t6_no_timeout", HEX_2, S_E);
`endif
      Inner_Sensor = 1'b0; token = 2'b00;
      step(8);
      chk("t6_backaway_h1", HEX_1, BLK);
      Inner_Sensor = 1'b1; token = 2'b11;
      step(7);
      chk("t6_open_h1", HEX_1, S_6); chk("t6_occ14", occupancy, 14);
      rst_in = 1'b0;
      #1;
      chk("t6_rst_g", G_LED, 0);     chk("t6_rst_h1", HEX_1, BLK);
      chk("t6_rst_h2", HEX_2, BLK);  chk("t6_rst_occ", occupancy, 0);
      chk("t6_rst_exit", exit_event, 0);
      Inner_Sensor = 1'b0; token = 2'b00;
      step(1);
      rst_in = 1'b1;
      step(2);
      chk("t6_post_h1", HEX_1, BLK); chk("t6_post_occ", occupancy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
